// File: rtl/dm_cache_pkg.sv
// Shared geometry, controller state encoding and address field helpers
// for the direct-mapped cache controller.
package dm_cache_pkg;

  localparam int unsigned TAG_W = 20;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned WORDS = 1 << OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL,
    RESPOND,
    FLUSH
  } state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
    return addr[IDX_W+OFF_W +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [31:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] offset_of(input logic [31:0] addr);
    return addr[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// CPU request/response and memory refill signals of the cache controller.
// slave = controller side, master = core/memory side.
interface dm_cache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/dm_cache_store.sv
// Tag, valid and data arrays: synchronous read of one line/word per cycle,
// single-word write, tag write (which also sets valid) and single-line invalidate.
module dm_cache_store
  import dm_cache_pkg::*;
#(
  parameter int unsigned TAG_BITS = TAG_W,
  parameter int unsigned INDEX_W  = IDX_W,
  parameter int unsigned OFFSET_W = OFF_W,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                word_we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                clr_en,
  input  logic [INDEX_W-1:0]  clr_index
);
  localparam int unsigned N_LINES = 1 << INDEX_W;
  localparam int unsigned N_WORDS = N_LINES << OFFSET_W;

  logic [TAG_BITS-1:0] tags [N_LINES];
  logic [DATA_W-1:0]   data [N_WORDS];
  logic [N_LINES-1:0]  valid;

  always_ff @(posedge clk) begin
    rd_tag  <= tags[rd_index];
    rd_word <= data[{rd_index, rd_offset}];
    if (word_we) data[{wr_index, wr_offset}] <= wr_data;
    if (tag_we)  tags[wr_index] <= wr_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= valid[rd_index];
      if (clr_en) valid[clr_index] <= 1'b0;
      if (tag_we) valid[wr_index]  <= 1'b1;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache request sequencer: tag lookup, 16-beat line refill,
// sequenced valid-bit flush and hit/miss counters.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_cache_if.slave         bus,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int unsigned TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q, lookup_addr;
  logic [OFFSET_W-1:0] beat;
  logic [INDEX_W-1:0]  flush_idx;
  logic                flush_pending, resp_pulse;
  logic [DATA_W-1:0]   resp_data_q;
  logic                rd_valid, hit, req_ready, mem_req_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [DATA_W-1:0]   rd_word;
  logic                word_we, tag_we, clr_en;

  // Array read is issued in the accept cycle so LOOKUP sees registered results.
  assign lookup_addr = (state == IDLE) ? bus.req_addr : addr_q;
  assign hit         = rd_valid && (rd_tag == tag_of(addr_q));

  dm_cache_store #(
    .TAG_BITS (TAG_BITS),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .DATA_W   (DATA_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (index_of(lookup_addr)),
    .rd_offset (offset_of(lookup_addr)),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .word_we   (word_we),
    .wr_index  (index_of(addr_q)),
    .wr_offset (beat),
    .wr_data   (bus.mem_rdata),
    .tag_we    (tag_we),
    .wr_tag    (tag_of(addr_q)),
    .clr_en    (clr_en),
    .clr_index (flush_idx)
  );

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    word_we       = 1'b0;
    tag_we        = 1'b0;
    clr_en        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !flush && !flush_pending;
        if (flush || flush_pending) state_nx = FLUSH;
        else if (bus.req_valid)     state_nx = LOOKUP;
      end
      LOOKUP:     state_nx = hit ? IDLE : REFILL_REQ;
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nx = REFILL;
      end
      REFILL: begin
        if (bus.mem_rvalid) begin
          word_we = 1'b1;
          if (beat == '1) begin
            tag_we   = 1'b1;
            state_nx = RESPOND;
          end
        end
      end
      RESPOND:    state_nx = IDLE;
      FLUSH: begin
        clr_en = 1'b1;
        if (flush_idx == '1) state_nx = IDLE;
      end
      default:    state_nx = IDLE;
    endcase
  end

  // Hit responses are a registered pulse issued from IDLE; the missed word is
  // captured as it streams past so RESPOND never reads a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      beat          <= '0;
      flush_idx     <= '0;
      flush_pending <= 1'b0;
      resp_pulse    <= 1'b0;
      resp_data_q   <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state      <= state_nx;
      resp_pulse <= 1'b0;
      if (state == FLUSH) begin
        if (flush_idx == '1) flush_pending <= 1'b0;
      end else if (state != IDLE && flush) begin
        flush_pending <= 1'b1;
      end
      case (state)
        IDLE: if (bus.req_valid && req_ready) addr_q <= bus.req_addr;
        LOOKUP: begin
          if (hit) begin
            hit_count   <= hit_count + 32'd1;
            resp_pulse  <= 1'b1;
            resp_data_q <= rd_word;
          end else begin
            miss_count  <= miss_count + 32'd1;
          end
        end
        REFILL_REQ: if (bus.mem_req_ready) beat <= '0;
        REFILL: begin
          if (bus.mem_rvalid) begin
            beat <= beat + 1'b1;
            if (beat == offset_of(addr_q)) resp_data_q <= bus.mem_rdata;
          end
        end
        FLUSH: flush_idx <= flush_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_req_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign bus.resp_valid    = resp_pulse || (state == RESPOND);
  assign bus.resp_hit      = resp_pulse;
  assign bus.resp_data     = resp_data_q;
  assign busy              = (state != IDLE);

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Request-sequencing controller for the direct-mapped instruction/data cache: 256 lines, 16 x 32-bit words per line, 20-bit tag, 8-bit index, 4-bit word offset. Accepts one CPU read at a time and performs the tag lookup. On a miss, runs a 16-beat line refill from the memory port. Also maintains hit/miss counters and a sequenced flush (valid-bit invalidation). Sits between the core load path and the memory model; owns the tag, valid and data arrays.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, word width
INDEX_W, 8, line index bits (lines = 2**INDEX_W)
OFFSET_W, 4, word-offset bits (words per line = 2**OFFSET_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU read request
req_ready  out  1  controller can accept a request this cycle
req_addr  in  ADDR_W  word address: tag=[31:12], index=[11:4], offset=[3:0]
resp_valid  out  1  one-cycle response pulse
resp_data  out  DATA_W  requested word
resp_hit  out  1  1 = served from cache, 0 = served after refill
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  memory accepts refill request
mem_req_addr  out  ADDR_W  line-aligned address {tag,index,4'b0}
mem_rvalid  in  1  refill data beat valid
mem_rdata  in  DATA_W  refill data beat
flush  in  1  invalidate-all request (pulse)
busy  out  1  state != IDLE
hit_count  out  32  total hits
miss_count  out  32  total misses

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all 256 valid bits=0; hit_count=miss_count=0.
  - resp_valid=0, mem_req_valid=0, flush_pending=0.
  - req_ready=1 once rst_n deasserts.
  - Tag/data arrays are not reset.
- Reset mid-operation: any refill in progress is abandoned with no response. Stray mem_rvalid beats after reset are ignored.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL, RESPOND, FLUSH.
- IDLE:
  - req_ready = !flush && !flush_pending.
  - Handshake req_valid&&req_ready latches the address -> LOOKUP.
  - flush or flush_pending -> FLUSH. Flush wins over a simultaneous request; that request is not accepted.
- LOOKUP (1 cycle, synchronous array read):
  - Hit (valid[index] && tag match): hit_count+1; next cycle resp_valid=1, resp_hit=1, resp_data=word[offset] -> IDLE. Hit latency = 2 cycles from accept.
  - Miss: miss_count+1 -> REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid=1 with mem_req_addr held stable until mem_req_ready.
  - On handshake -> REFILL, beat counter=0.
- REFILL:
  - Each mem_rvalid writes mem_rdata to word[beat]; beat+1. Beats arrive in order 0..15; gaps are allowed.
  - On beat 15: tag[index]=tag, valid[index]=1 -> RESPOND.
- RESPOND: resp_valid=1, resp_hit=0, resp_data=refilled word[offset] -> IDLE. Miss latency = 3 + memory grant delay + beat cycles.
- FLUSH:
  - Clears one valid bit per cycle, index 0..255 (256 cycles), then -> IDLE, flush_pending=0.
  - Counters are not affected.
- flush asserted in any state other than IDLE/FLUSH sets flush_pending. The in-flight request completes first.
- mem_rvalid outside REFILL is ignored. No response backpressure; resp_valid is a single-cycle pulse.
- Counters wrap modulo 2**32.
- hit_count/miss_count update at the end of the LOOKUP cycle. resp_data is don't-care when resp_valid=0.

Decomposition:
- Package dm_cache_pkg: geometry localparams (TAG_W=20, LINES=256, WORDS=16), state enum, and address field-slice functions (tag_of, index_of, offset_of).
- One sub-module, dm_cache_store: tag/valid/data arrays with synchronous read, word write, tag write and single-index valid clear.
- dm_cache_ctrl holds the FSM, beat counter, flush index and counters.

Test Plan:
- Cold miss: read 0x0000_1234 (idx 0x23, off 4, tag 0x00001). Memory returns beat k = 0x1230+k. -> mem_req_addr=0x0000_1230, 16 beats, resp_data=0x1234, resp_hit=0, miss_count=1.
- Hit after fill: read 0x0000_123F -> resp_valid 2 cycles after accept, resp_data=0x123F, resp_hit=1, hit_count=1, no mem_req_valid.
- Conflict: read 0x0000_2234 (same idx, tag 0x00002) -> miss, refill from 0x0000_2230. Re-read 0x0000_1234 -> miss again; miss_count=3.
- Memory backpressure: hold mem_req_ready=0 for 5 cycles and insert 1-cycle gaps between beats -> mem_req_addr stable throughout, correct data, exactly one response.
- Flush: with line 0x23 valid, pulse flush together with req_valid. -> request not accepted; busy for 256 cycles; then read 0x0000_1234 misses; counters unchanged by the flush.
- Reset mid-refill: drop rst_n after beat 7 -> no resp_valid, valid bits cleared, counters=0, req_ready=1 after release. Subsequent read 0x0000_1234 misses.
